// File: rtl/modmul_fold_1601.sv
// Sequential modular-multiply front end for q=1601.
// Shift-add multiply (one multiplier bit per cycle), then a single
// congruence-preserving subtraction of Q<<10 so the product fits 21 bits.
module modmul_fold_1601 #(
  parameter int Q      = 1601,
  parameter int W      = 11,
  parameter int DOUT_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      din_a,
  input  logic [W-1:0]      din_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] dout,
  output logic              range_err
);

  localparam int ACC_W = 2 * W;
  localparam int CNT_W = $clog2(W);
  localparam logic [ACC_W-1:0] FOLD_K   = ACC_W'(Q << 10);
  localparam logic [W-1:0]     Q_W      = W'(Q);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {IDLE, MUL, FOLD, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     a_q, b_q;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; handshake outputs depend on state only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL;
      end
      MUL:  if (cnt == CNT_LAST) state_nxt = FOLD;
      FOLD: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add accumulate, single fold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= din_a;
          b_q <= din_b;
          acc <= '0;
          cnt <= '0;
          err <= (din_a >= Q_W) | (din_b >= Q_W);
        end
        MUL: begin
          if (b_q[cnt]) acc <= acc + (ACC_W'(a_q) << cnt);
          cnt <= cnt + 1'b1;
        end
        FOLD: if (acc >= FOLD_K) acc <= acc - FOLD_K;
        default: ;
      endcase
    end
  end

  // Result is only presented in DONE; zero otherwise (including under reset)
  always_comb begin
    dout      = '0;
    range_err = 1'b0;
    if (state == DONE) begin
      dout      = acc[DOUT_W-1:0];
      range_err = err;
    end
  end

endmodule
